// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
//
// Multi-cycle ALU. Logic operations and ADD finish one cycle after start.
// Logical shifts move B by one bit position per cycle, so a shift by k takes
// k+1 cycles from the accepting edge to the done pulse.
//
// Optional feature: define ITERATIVE_ALU_OVERFLOW_EN to add the Overflow
// output, which reports signed overflow of ADD. Without the macro the port
// does not exist and all other behaviour is identical.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   request one operation (honoured in IDLE and DONE only)
//   ALUOperation in   4-bit operation code
//   A, B         in   operands (B is the shifted operand)
//   shamt        in   shift amount, 0..31
//   busy         out  high while a shift is in progress
//   done         out  one-cycle pulse, ALUResult valid
//   ALUResult    out  registered result, held until the next completion
//   Zero         out  registered, high when ALUResult == 0
//   Overflow     out  (ITERATIVE_ALU_OVERFLOW_EN only) signed ADD overflow
//   state_o      out  current FSM state, for debug and checkers
//
// Handshake: start is sampled on every rising edge, but an operation is
// accepted only when the FSM is in IDLE or DONE; starts seen in SHIFT are
// dropped. Each accepted operation produces exactly one done pulse unless
// reset intervenes. A start in DONE is accepted in that same cycle, so
// back-to-back operations lose no cycle.
// -----------------------------------------------------------------------------
module iterative_alu #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [NBits-1:0] A,
  input  logic [NBits-1:0] B,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [NBits-1:0] ALUResult,
  output logic             Zero,
`ifdef ITERATIVE_ALU_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  state_t           state_q, state_d;
  logic [NBits-1:0] sh_q, sh_d;        // operand being shifted
  logic [4:0]       cnt_q, cnt_d;      // shifts still to perform
  logic             left_q, left_d;    // 1 = SLL, 0 = SRL
  logic [NBits-1:0] result_q, result_d;
  logic             zero_q, zero_d;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             accept;
  logic [NBits-1:0] sum;
  logic [NBits-1:0] imm_res;           // single-cycle result of the new op
  logic             add_ovf;
  logic [NBits-1:0] shifted;           // sh_q moved by one position

  assign sum     = A + B;
  assign add_ovf = (A[NBits-1] == B[NBits-1]) && (sum[NBits-1] != A[NBits-1]);
  assign shifted = left_q ? (sh_q << 1) : (sh_q >> 1);
  assign accept  = start && ((state_q == IDLE) || (state_q == DONE));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif

    // Result of the incoming op when it completes in one cycle. A shift
    // only lands here when shamt is 0, in which case the result is B.
    case (ALUOperation)
      OP_AND:  imm_res = A & B;
      OP_OR:   imm_res = A | B;
      OP_NOR:  imm_res = ~(A | B);
      OP_ADD:  imm_res = sum;
      OP_SLL,
      OP_SRL:  imm_res = B;
      default: imm_res = '0;
    endcase

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (((ALUOperation == OP_SLL) || (ALUOperation == OP_SRL)) &&
              (shamt != 5'd0)) begin
            state_d = SHIFT;
            sh_d    = B;
            cnt_d   = shamt;
            left_d  = (ALUOperation == OP_SLL);
          end else begin
            state_d  = DONE;
            result_d = imm_res;
            zero_d   = (imm_res == '0);
`ifdef ITERATIVE_ALU_OVERFLOW_EN
            ovf_d    = (ALUOperation == OP_ADD) && add_ovf;
`endif
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sh_d  = shifted;
        cnt_d = cnt_q - 5'd1;
        // Last shift: publish the result as the FSM enters DONE.
        if (cnt_q == 5'd1) begin
          state_d  = DONE;
          result_d = shifted;
          zero_d   = (shifted == '0);
`ifdef ITERATIVE_ALU_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign state_o   = state_q;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
  assign Overflow  = ovf_q;
`endif

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter NBits, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one operation; sampled on the rising clk edge.
REQ-005 SHALL have port ALUOperation  input  4  operation code from the ALU control unit.
REQ-006 SHALL have port A  input  NBits  first operand, used by logic and add operations.
REQ-007 SHALL have port B  input  NBits  second operand, and the shifted operand for shifts.
REQ-008 SHALL have port shamt  input  5  shift amount; the datapath supplies 16 for LUI.
REQ-009 SHALL have port busy  output  1  high while a shift is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid ALUResult.
REQ-011 SHALL have port ALUResult  output  NBits  registered result, held until the next accepted operation completes.
REQ-012 SHALL have port Zero  output  1  registered; high when ALUResult equals 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE; the only exit from DONE is after exactly one cycle.
REQ-014 SHALL accept start only in IDLE or DONE, capturing ALUOperation, A, B and shamt at the accepting edge (cycle N); start SHALL be ignored in SHIFT.
REQ-015 SHALL, for codes 0000 (AND), 0001 (OR), 0010 (NOR) and 0011 (ADD, modulo 2^NBits, carry discarded), enter DONE at N+1 with the result registered.
REQ-016 SHALL, for codes 0101 (SLL) and 0110 (SRL) with shamt=k≥1, enter SHIFT and shift B by one bit per cycle, zero-filling, then enter DONE at N+k+1.
REQ-017 SHALL, for SLL/SRL with shamt=0, enter DONE at N+1 with ALUResult=B.
REQ-018 SHALL, for any other code (including 1001), enter DONE at N+1 with ALUResult=0 and Zero=1.
REQ-019 SHALL assert busy only in SHIFT and done only in DONE.
REQ-020 SHALL, when start is high in DONE, accept the new operation so that back-to-back operations lose no cycle.
REQ-021 SHALL return from DONE to IDLE when start is low.
REQ-022 SHALL update ALUResult and Zero only on entry to DONE; their values SHALL be stable during SHIFT and IDLE.
REQ-023 SHALL treat shamt values up to 31 as legal; NBits-1 shifts of a 1 SHALL leave only the end bit set.

Reset
REQ-024 SHALL, while reset is high, force state to IDLE and force busy=0, done=0, ALUResult=0, Zero=1 and the internal shift register to 0, independent of clk.
REQ-025 SHALL abandon an operation interrupted by reset mid-SHIFT, with no done pulse afterwards.
REQ-026 SHALL accept start on the first rising clk edge after reset deasserts.

Configuration
REQ-027 SHALL, with macro ITERATIVE_ALU_OVERFLOW_EN defined, add output Overflow (1 bit, reset 0), set in DONE for ADD when A and B have equal signs and the result sign differs, and 0 otherwise.
REQ-028 SHALL, without ITERATIVE_ALU_OVERFLOW_EN, have no Overflow port, with all other behaviour identical.

Verification
REQ-029 SHALL cover: ADD with A=0x00000005, B=0x00000003, start at N -> done=1 at N+1, ALUResult=0x00000008, Zero=0, busy never high.
REQ-030 SHALL cover: SLL with B=0x0000ABCD, shamt=16 (LUI) -> busy high N+1..N+16, done at N+17, ALUResult=0xABCD0000.
REQ-031 SHALL cover: SRL with B=0x80000000, shamt=31, plus a start pulse during SHIFT -> that start is ignored, done at N+32, ALUResult=0x00000001.
REQ-032 SHALL cover: code 1001 -> done at N+1, ALUResult=0, Zero=1; then a back-to-back NOR of 0xFFFFFFFF and 0 started in DONE -> done at the next cycle with ALUResult=0, Zero=1.
REQ-033 SHALL cover: reset asserted at SHIFT cycle 3 of an SLL with shamt=10 -> busy, done and ALUResult go to 0 immediately, Zero=1, no later done pulse.
REQ-034 SHALL cover, with ITERATIVE_ALU_OVERFLOW_EN defined: ADD of 0x7FFFFFFF and 0x00000001 -> ALUResult=0x80000000, Overflow=1.
